adc_capture_buffer: RTL

//  Receive end of the ADC sample interface: accepts 8-bit ADC codes on each sample strobe.

---
 rtl/osc_capture_pkg.sv | 15 +
 rtl/capture_ram.sv | 32 +++
 rtl/adc_capture_buffer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/osc_capture_pkg.sv
// Shared types and default widths for the ADC capture buffer and its RAM.
package osc_capture_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, registered one-cycle read port.
module capture_ram
  import osc_capture_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the output register is reset; the array itself keeps its contents.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rdata <= '0;
    else          r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_capture_buffer.sv
// Circular ADC capture with pre/post-trigger framing and edge trigger.
// Optional forced trigger on timeout: define ADC_CAPTURE_AUTO_TRIG_EN.
module adc_capture_buffer
  import osc_capture_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned PRE_TRIG     = 512,
  parameter int unsigned AUTO_TIMEOUT = 4096
) (
  input  logic              clk_50mHZ,
  input  logic              reset_n,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic              auto_trig,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam int unsigned       DEPTH    = 2**ADDR_W;
  localparam int unsigned       POST_LEN = DEPTH - PRE_TRIG;
  localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_LEN - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE_TRIG);

  cap_state_t        r_state, w_state_next;
  logic [ADDR_W-1:0] r_wr_ptr, r_cnt, r_trig_addr, w_rd_phys;
  logic [DATA_W-1:0] r_prev;
  logic              r_prev_valid, r_triggered, r_done, r_busy, r_auto_trig;
  logic              w_we, w_fire, w_edge, w_auto_fire;

  assign w_edge = r_prev_valid &&
                  (trig_rising ? (r_prev < trig_level && adc_data >= trig_level)
                               : (r_prev > trig_level && adc_data <= trig_level));

`ifdef ADC_CAPTURE_AUTO_TRIG_EN
  localparam int unsigned   TO_W    = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(AUTO_TIMEOUT - 1);
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk_50mHZ or negedge reset_n) begin
    if (!reset_n)                         r_to_cnt <= '0;
    else if (arm || r_state != WAIT_TRIG) r_to_cnt <= '0;
    else if (sample_tick)                 r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign w_auto_fire = (r_state == WAIT_TRIG) && (r_to_cnt == TO_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (AUTO_TIMEOUT != 0);
  assign w_auto_fire      = 1'b0;
`endif

  always_ff @(posedge clk_50mHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == PRE) || (w_state_next == WAIT_TRIG) ||
                 (w_state_next == POST);
      r_done  <= (w_state_next == DONE);
    end
  end

  // arm outranks a same-cycle tick, so the strobe is only honoured without arm.
  always_comb begin
    w_state_next = r_state;
    w_we         = 1'b0;
    w_fire       = 1'b0;
    if (arm) begin
      w_state_next = PRE;
    end else if (sample_tick) begin
      case (r_state)
        PRE: begin
          w_we = 1'b1;
          if (r_cnt == PRE_LAST) w_state_next = WAIT_TRIG;
        end
        WAIT_TRIG: begin
          w_we = 1'b1;
          if (w_edge || w_auto_fire) begin
            w_fire       = 1'b1;
            w_state_next = (POST_LEN == 1) ? DONE : POST;
          end
        end
        POST: begin
          w_we = 1'b1;
          if (r_cnt == POST_LAST) w_state_next = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50mHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_cnt        <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_trig_addr  <= '0;
      r_triggered  <= 1'b0;
      r_auto_trig  <= 1'b0;
    end else if (arm) begin
      r_cnt        <= '0;
      r_prev_valid <= 1'b0;
      r_triggered  <= 1'b0;
      r_auto_trig  <= 1'b0;
    end else if (w_we) begin
      r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
      r_prev       <= adc_data;
      r_prev_valid <= 1'b1;
      if (w_fire) begin
        r_cnt       <= ADDR_W'(1);
        r_trig_addr <= r_wr_ptr;
        r_triggered <= 1'b1;
        r_auto_trig <= w_auto_fire && !w_edge;
      end else if (r_state == PRE && r_cnt == PRE_LAST) begin
        r_cnt <= '0;
      end else if (r_state != WAIT_TRIG) begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end
    end
  end

  assign w_rd_phys = r_trig_addr - PRE_OFS + rd_addr;

  capture_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .i_clk  (clk_50mHZ),
    .i_rst_n(reset_n),
    .i_we   (w_we),
    .i_waddr(r_wr_ptr),
    .i_wdata(adc_data),
    .i_raddr(w_rd_phys),
    .o_rdata(rd_data)
  );

  assign busy      = r_busy;
  assign triggered = r_triggered;
  assign done      = r_done;
  assign auto_trig = r_auto_trig;
  assign trig_addr = r_trig_addr;

endmodule
